memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  Memory stage of the 5-stage pipeline: EX/MEM pipeline register, data-memory access, load/store formatting.
//  Feeds the writeback stage: RegWriteM, ResultSrcM, ALUResultM, ReadDataM, PCPlus4M, RdM.
//  Data memory uses a req/ack handshake; while an access is outstanding, StallM freezes upstream stages.
// PARAMETERS
//  word_width  32  datapath width; byte lanes = word_width/8
//  MAX_WAIT    15  cycles with req high and no ack before a bus error is declared (>=1)
// PORTS
//  clk         in   1    clock, rising edge
//  reset       in   1    synchronous, active-low
//  RegWriteE   in   1    EX-stage register-write enable
//  ResultSrcE  in   2    00 ALU, 01 load data, 10 PC+4
//  MemWriteE   in   1    store
//  Funct3E     in   3    access size/sign (RV32I encoding)
//  ALUResultE  in   ww   effective address / ALU result
//  WriteDataE  in   ww   store data (rs2)
//  PCPlus4E    in   ww   PC+4
//  RdE         in   5    destination register
//  dmem_req    out  1    access request
//  dmem_we     out  1    1 = write
//  dmem_addr   out  ww   word-aligned address (low 2 bits zero)
//  dmem_be     out  ww/8 byte enables
//  dmem_wdata  out  ww   lane-replicated store data
//  dmem_rdata  in   ww   read word, valid when dmem_ack=1
//  dmem_ack    in   1    access complete this cycle
//  RegWriteM   out  1    to writeback (gated, see below)
//  ResultSrcM  out  2    to writeback
//  ALUResultM  out  ww   to writeback
//  ReadDataM   out  ww   formatted load data
//  PCPlus4M    out  ww   to writeback
//  RdM         out  5    to writeback
//  StallM      out  1    hold IF/ID/EX and this stage's register
//  MisalignM   out  1    1-cycle pulse: misaligned access dropped
//  BusErrM     out  1    1-cycle pulse: MAX_WAIT exceeded
// BEHAVIOUR
//  EX/MEM register loads all *E inputs each edge when StallM=0; holds when StallM=1.
//  Reset (reset=0 at edge): register cleared (RegWrite/MemWrite=0, ResultSrc=00, data 0),
//   FSM->RUN, wait counter 0. All outputs 0 in the following cycle; a pending access is abandoned.
//  Memory op = MemWrite | (ResultSrc==01). Misaligned = half with addr[0]=1, or word with addr[1:0]!=0.
//  FSM states RUN, WAIT:
//   RUN:  mem op and aligned -> dmem_req=1. ack same cycle -> stay RUN, StallM=0.
//         No ack -> WAIT, StallM=1. Non-mem op or misaligned -> dmem_req=0, StallM=0.
//   WAIT: dmem_req=1 and request outputs held stable. StallM=1 until ack.
//         ack -> RUN, StallM=0. Counter reaches MAX_WAIT with no ack -> BusErrM=1,
//         StallM=0, RUN; instruction retires with RegWriteM=0.
//  Counter: 0 in RUN, +1 per WAIT cycle, saturates at MAX_WAIT.
//  Latency: zero-wait access adds 0 cycles. Each ack delay cycle adds one stall cycle.
//  RegWriteM = RegWrite_q & ~StallM & ~MisalignM & ~BusErrM. Writeback samples every cycle,
//   so a load writes exactly once, in its ack cycle.
//  MisalignM: asserted combinationally for the one cycle the instruction sits in M; no stall.
//  Store (Funct3 000/001/010 = sb/sh/sw): be = 0001<<a[1:0], 0011<<a[1:0], 1111.
//   wdata = byte x4, half x2, word.
//  Load: lane selected by addr[1:0]; 000 lb/001 lh sign-extend, 100 lbu/101 lhu zero-extend,
//   010 lw passthrough. be = all ones on reads.
//  Undefined Funct3 on load/store: treated as word.
//  ReadDataM formatted combinationally from dmem_rdata; valid only in the ack cycle (0 otherwise).
//  Non-mem ops pass ALUResult/PCPlus4/Rd/ResultSrc through unchanged.
//  ack while req=0: ignored.
// TESTING
//  lw addr 0x100, ack same cycle, rdata 0xDEADBEEF -> ReadDataM=0xDEADBEEF, RegWriteM=1 one cycle, StallM never 1.
//  lb addr 0x103, rdata 0x80FF_FFFF, ack after 3 cycles -> StallM=1 for 3 cycles, RegWriteM=0 then 1;
//   ReadDataM=0xFFFFFF80.
//  sh addr 0x202, data 0x1234ABCD -> be=1100, wdata=0xABCDABCD, we=1, RegWriteM=0.
//  lw addr 0x101 -> MisalignM=1 one cycle, dmem_req=0, RegWriteM=0, no stall.
//  MAX_WAIT=4, never ack -> 4 stall cycles, BusErrM pulse, StallM drops, next instruction proceeds.
//  reset=0 during WAIT -> next cycle dmem_req=0, StallM=0, RegWriteM=0, FSM=RUN.

Source files
------------

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - EX/MEM pipeline register, req/ack data-memory access, load/store formatting
module memory_stage #(
    parameter int word_width = 32,
    parameter int MAX_WAIT   = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      RegWriteE,
    input  logic [1:0]                ResultSrcE,
    input  logic                      MemWriteE,
    input  logic [2:0]                Funct3E,
    input  logic [word_width-1:0]     ALUResultE,
    input  logic [word_width-1:0]     WriteDataE,
    input  logic [word_width-1:0]     PCPlus4E,
    input  logic [4:0]                RdE,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [word_width-1:0]     dmem_addr,
    output logic [word_width/8-1:0]   dmem_be,
    output logic [word_width-1:0]     dmem_wdata,
    input  logic [word_width-1:0]     dmem_rdata,
    input  logic                      dmem_ack,
    output logic                      RegWriteM,
    output logic [1:0]                ResultSrcM,
    output logic [word_width-1:0]     ALUResultM,
    output logic [word_width-1:0]     ReadDataM,
    output logic [word_width-1:0]     PCPlus4M,
    output logic [4:0]                RdM,
    output logic                      StallM,
    output logic                      MisalignM,
    output logic                      BusErrM
);
    localparam int NB = word_width / 8;
    localparam int LB = $clog2(NB);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic {S_RUN, S_WAIT} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic                  r_regwrite;
    logic [1:0]            r_resultsrc;
    logic                  r_memwrite;
    logic [2:0]            r_funct3;
    logic [word_width-1:0] r_alu;
    logic [word_width-1:0] r_wdata;
    logic [word_width-1:0] r_pcplus4;
    logic [4:0]            r_rd;

    logic                  w_memop;
    logic                  w_is_byte;
    logic                  w_is_half;
    logic                  w_misalign;
    logic                  w_req;
    logic                  w_timeout;
    logic                  w_stall;
    logic                  w_buserr;
    logic [LB-1:0]         w_off;
    logic [NB-1:0]         w_store_be;
    logic [word_width-1:0] w_store_data;
    logic [word_width-1:0] w_lane;
    logic                  w_signed;
    logic [word_width-1:0] w_load_fmt;

    assign w_memop = r_memwrite | (r_resultsrc == 2'b01);
    assign w_off   = r_alu[LB-1:0];

    // Stores decode sb/sh strictly; loads also accept lbu/lhu. Anything else is a word access.
    assign w_is_byte = r_memwrite ? (r_funct3 == 3'b000) : (r_funct3[1:0] == 2'b00);
    assign w_is_half = r_memwrite ? (r_funct3 == 3'b001) : (r_funct3[1:0] == 2'b01);

    assign w_misalign = w_is_half ? r_alu[0] :
                        w_is_byte ? 1'b0 : (w_off != '0);

    assign w_req     = (r_state == S_WAIT) | (w_memop & ~w_misalign);
    assign w_timeout = (r_state == S_WAIT) && (r_cnt == CW'(MAX_WAIT));
    assign w_buserr  = w_timeout & ~dmem_ack;
    assign w_stall   = w_req & ~dmem_ack & ~w_timeout;

    assign w_store_be   = w_is_byte ? (NB'(1) << w_off) :
                          w_is_half ? (NB'(3) << w_off) : '1;
    assign w_store_data = w_is_byte ? {NB{r_wdata[7:0]}} :
                          w_is_half ? {(NB/2){r_wdata[15:0]}} : r_wdata;

    assign w_lane   = dmem_rdata >> {w_off, 3'b000};
    assign w_signed = ~r_funct3[2];
    assign w_load_fmt = w_is_byte ? {{(word_width-8){w_signed & w_lane[7]}}, w_lane[7:0]} :
                        w_is_half ? {{(word_width-16){w_signed & w_lane[15]}}, w_lane[15:0]} :
                        w_lane;

    assign dmem_req   = w_req;
    assign dmem_we    = w_req & r_memwrite;
    assign dmem_addr  = w_req ? {r_alu[word_width-1:LB], {LB{1'b0}}} : '0;
    assign dmem_be    = w_req ? (r_memwrite ? w_store_be : '1) : '0;
    assign dmem_wdata = (w_req & r_memwrite) ? w_store_data : '0;

    assign StallM     = w_stall;
    assign BusErrM    = w_buserr;
    assign MisalignM  = w_memop & w_misalign;
    assign RegWriteM  = r_regwrite & ~w_stall & ~MisalignM & ~w_buserr;
    assign ReadDataM  = (w_req & dmem_ack & ~r_memwrite) ? w_load_fmt : '0;
    assign ResultSrcM = r_resultsrc;
    assign ALUResultM = r_alu;
    assign PCPlus4M   = r_pcplus4;
    assign RdM        = r_rd;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_regwrite  <= 1'b0;
            r_resultsrc <= 2'b00;
            r_memwrite  <= 1'b0;
            r_funct3    <= '0;
            r_alu       <= '0;
            r_wdata     <= '0;
            r_pcplus4   <= '0;
            r_rd        <= '0;
        end else if (!w_stall) begin
            r_regwrite  <= RegWriteE;
            r_resultsrc <= ResultSrcE;
            r_memwrite  <= MemWriteE;
            r_funct3    <= Funct3E;
            r_alu       <= ALUResultE;
            r_wdata     <= WriteDataE;
            r_pcplus4   <= PCPlus4E;
            r_rd        <= RdE;
        end
    end

    // r_cnt counts request cycles without ack, including the first one issued from RUN.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            if (w_req && !dmem_ack) begin
                r_state <= S_WAIT;
                r_cnt   <= CW'(1);
            end else begin
                r_cnt   <= '0;
            end
        end else begin
            if (dmem_ack || w_timeout) begin
                r_state <= S_RUN;
                r_cnt   <= '0;
            end else if (r_cnt != CW'(MAX_WAIT)) begin
                r_cnt   <= r_cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - randomized bench for memory_stage against a transaction-level model
module tb_memory_stage;
    localparam int WW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          RegWriteE, MemWriteE, dmem_ack;
    logic [1:0]    ResultSrcE;
    logic [2:0]    Funct3E;
    logic [WW-1:0] ALUResultE, WriteDataE, PCPlus4E, dmem_rdata;
    logic [4:0]    RdE;
    logic          dmem_req, dmem_we, RegWriteM, StallM, MisalignM, BusErrM;
    logic [WW-1:0] dmem_addr, dmem_wdata, ALUResultM, ReadDataM, PCPlus4M;
    logic [3:0]    dmem_be;
    logic [1:0]    ResultSrcM;
    logic [4:0]    RdM;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_stage #(.word_width(WW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE), .Funct3E(Funct3E),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E), .RdE(RdE),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM),
        .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
        .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM)
    );

    typedef struct {
        bit        rw;
        bit [1:0]  rsrc;
        bit        mw;
        bit [2:0]  f3;
        bit [31:0] alu;
        bit [31:0] wd;
        bit [31:0] pc;
        bit [31:0] rdata;
        bit [4:0]  rd;
        int        d;
    } instr_t;

    instr_t q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic instr_t mk(bit rw, bit [1:0] rsrc, bit mw, bit [2:0] f3,
                                  bit [31:0] alu, bit [31:0] wd, bit [31:0] rdata, int d);
        instr_t x;
        x.rw = rw; x.rsrc = rsrc; x.mw = mw; x.f3 = f3; x.alu = alu; x.wd = wd;
        x.rdata = rdata; x.d = d; x.pc = $urandom; x.rd = 5'($urandom_range(0, 31));
        return x;
    endfunction

    function automatic instr_t rand_instr();
        instr_t x;
        int kind;
        kind = $urandom_range(0, 3);
        x = mk(1'($urandom_range(0, 1)), 2'b00, 1'b0, 3'($urandom_range(0, 7)),
               $urandom, $urandom, $urandom, $urandom_range(0, 6));
        if (kind <= 1) x.rsrc = 2'b01;
        else if (kind == 2) x.mw = 1'b1;
        else x.rsrc = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
        if ($urandom_range(0, 9) < 7) x.alu = x.alu & 32'hFFFF_FFFC;
        return x;
    endfunction

    function automatic int size_of(instr_t x);
        if (x.mw) return (x.f3 == 0) ? 1 : (x.f3 == 1) ? 2 : 4;
        if (x.f3 == 0 || x.f3 == 4) return 1;
        if (x.f3 == 1 || x.f3 == 5) return 2;
        return 4;
    endfunction

    function automatic bit [31:0] fmt_load(instr_t x);
        bit [31:0] v;
        int sz;
        sz = size_of(x);
        v = x.rdata >> (8 * (x.alu % 4));
        if (sz == 1) begin
            v = v % 256;
            if (x.f3 == 0 && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v % 65536;
            if (x.f3 == 1 && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic drive_e(instr_t x);
        RegWriteE = x.rw; ResultSrcE = x.rsrc; MemWriteE = x.mw; Funct3E = x.f3;
        ALUResultE = x.alu; WriteDataE = x.wd; PCPlus4E = x.pc; RdE = x.rd;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_req"}, dmem_req, 0);
        check({tag, "_stall"}, StallM, 0);
        check({tag, "_regwrite"}, RegWriteM, 0);
        check({tag, "_buserr"}, BusErrM, 0);
        check({tag, "_readdata"}, ReadDataM, 0);
    endtask

    initial begin
        instr_t c, nxt, nop, w;
        bit mem, mis, acc, ld_ack, berr, stall;
        int sz;
        nop = mk(0, 2'b00, 0, 3'b000, 0, 0, 0, 0);
        nop.pc = 0; nop.rd = 0;

        reset = 1'b0;
        drive_e(rand_instr());
        dmem_ack = 1'b1;
        dmem_rdata = $urandom;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        check("reset_misalign", MisalignM, 0);
        check("reset_alu", ALUResultM, 0);
        check("reset_pc", PCPlus4M, 0);
        check("reset_rd", RdM, 0);
        check("reset_rsrc", ResultSrcM, 0);

        q.push_back(mk(1, 2'b01, 0, 3'b010, 32'h100, 0, 32'hDEAD_BEEF, 0));
        q.push_back(mk(1, 2'b01, 0, 3'b000, 32'h103, 0, 32'h80FF_FFFF, 3));
        q.push_back(mk(0, 2'b00, 1, 3'b001, 32'h202, 32'h1234_ABCD, 0, 0));
        q.push_back(mk(1, 2'b01, 0, 3'b010, 32'h101, 0, 0, 0));
        q.push_back(mk(1, 2'b01, 0, 3'b010, 32'h300, 0, 0, 99));
        q.push_back(mk(1, 2'b00, 0, 3'b000, 32'h5555, 0, 0, 0));
        for (int n = 0; n < 300; n++) q.push_back(rand_instr());

        reset = 1'b1;
        dmem_ack = 1'b0;
        drive_e(q[0]);
        @(posedge clk);

        for (int i = 0; i < q.size(); i++) begin
            c   = q[i];
            nxt = (i + 1 < q.size()) ? q[i + 1] : nop;
            sz  = size_of(c);
            mem = c.mw || (c.rsrc == 2'b01);
            mis = mem && ((c.alu % sz) != 0);
            acc = mem && !mis;
            for (int k = 0; k <= MW + 1; k++) begin
                ld_ack = acc && (k == c.d);
                berr   = acc && (k == MW) && (c.d > MW);
                stall  = acc && !ld_ack && !berr;
                #1;
                dmem_ack   = acc ? ld_ack : 1'($urandom_range(0, 1));
                dmem_rdata = ld_ack ? c.rdata : $urandom;
                drive_e(nxt);
                @(negedge clk);
                check("req", dmem_req, acc);
                if (acc) begin
                    check("we", dmem_we, c.mw);
                    check("addr", dmem_addr, c.alu & 32'hFFFF_FFFC);
                    if (c.mw) begin
                        check("be", dmem_be, (sz == 1) ? (1 << (c.alu % 4)) :
                                             (sz == 2) ? (3 << (c.alu % 4)) : 15);
                        check("wdata", dmem_wdata, (sz == 1) ? (c.wd % 256) * 32'h0101_0101 :
                                                   (sz == 2) ? (c.wd % 65536) * 32'h0001_0001 : c.wd);
                    end else begin
                        check("be_load", dmem_be, 15);
                    end
                end
                check("stall", StallM, stall);
                check("misalign", MisalignM, mis);
                check("buserr", BusErrM, berr);
                check("regwrite", RegWriteM, c.rw && !stall && !mis && !berr);
                if (!(c.mw && ld_ack))
                    check("readdata", ReadDataM, (ld_ack && !c.mw) ? fmt_load(c) : 0);
                check("alu_m", ALUResultM, c.alu);
                check("pc_m", PCPlus4M, c.pc);
                check("rd_m", RdM, c.rd);
                check("rsrc_m", ResultSrcM, c.rsrc);
                @(posedge clk);
                if (!stall) break;
            end
        end

        w = mk(1, 2'b01, 0, 3'b010, 32'h40, 0, 0, 99);
        #1;
        dmem_ack = 1'b0;
        drive_e(w);
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        check("rstwait_stall0", StallM, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rstwait_stall1", StallM, 1);
        check("rstwait_req1", dmem_req, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        dmem_ack = 1'b1;
        drive_e(nop);
        @(negedge clk);
        check_idle("rstwait_after");
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        check_idle("rstwait_run");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
